link_receiver: RTL



---
 rtl/link_pkg.sv | 19 +
 rtl/link_sync2.sv | 30 +++
 rtl/link_receiver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the inter-board link receiver.
//   link_state_e    : receiver FSM state encoding
//   LINK_BIT_CYCLES : default clk cycles per transmitted bit
//   IDLE_WORD       : all-ones word the downstream consumer treats as idle
//                     (filtering is done by the consumer, not here)
package link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_DONE   = 3'd4
  } link_state_e;

  localparam int unsigned LINK_BIT_CYCLES = 8;
  localparam logic [31:0] IDLE_WORD       = 32'hFFFF_FFFF;

endpackage

// File: rtl/link_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk    : system clock
//   resetn : synchronous reset, active-low (both flops clear to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles behind d_i
module link_sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/link_receiver.sv
// Serial word receiver for the inter-board link. com_en frames a transfer,
// data_in carries the payload MSB first, one bit every BIT_CYCLES clocks.
// The first capture lands BIT_CYCLES/2 + BIT_CYCLES clocks after the
// synchronized com_en rise, so the peer's first bit period after raising
// com_en is a lead-in and the payload occupies the WIDTH bit periods after it.
// Optional build macro: LINK_PARITY_EN (one trailing even-parity bit).
// Ports:
//   clk       : system clock
//   resetn    : synchronous reset, active-low
//   data_in   : serial data from peer (asynchronous)
//   com_en    : frame enable from peer (asynchronous)
//   data      : last good received word
//   data_rdy  : high for RDY_HOLD cycles after each good frame
//   frame_err : one-cycle pulse on an aborted or bad frame
//   bit_cnt   : bits captured in the current frame (debug)
module link_receiver
  import link_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BIT_CYCLES = LINK_BIT_CYCLES,
  parameter int unsigned RDY_HOLD   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_in,
  input  logic             com_en,
  output logic [WIDTH-1:0] data,
  output logic             data_rdy,
  output logic             frame_err,
  output logic [7:0]       bit_cnt
);

  localparam logic [7:0] PH_HALF   = 8'(BIT_CYCLES / 2 - 1);
  localparam logic [7:0] PH_FULL   = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] LAST_BIT  = 8'(WIDTH - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(RDY_HOLD);

`ifdef LINK_PARITY_EN
  // Even parity: payload XOR parity bit must be 0 for a good frame.
  function automatic logic parity_bad(input logic [WIDTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction
`endif

  logic             com_s;
  logic             din_s;
  logic             com_rise_s;
  logic             load_s;
  logic [WIDTH-1:0] shift_word_s;

  link_state_e      state_q, state_d;
  logic [7:0]       phase_q, phase_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       hold_q, hold_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic [1:0]       settle_q, settle_d;
  logic             low_q, low_d;

  link_sync2 u_sync_com (.clk(clk), .resetn(resetn), .d_i(com_en),  .q_o(com_s));
  link_sync2 u_sync_din (.clk(clk), .resetn(resetn), .d_i(data_in), .q_o(din_s));

  // low_q only arms once the synchronizers hold real samples, so a com_en
  // that is already high when reset is released never looks like a rise.
  assign settle_d     = {settle_q[0], 1'b1};
  assign low_d        = settle_q[1] & ~com_s;
  assign com_rise_s   = com_s & low_q;
  assign shift_word_s = {sr_q[WIDTH-2:0], din_s};

  // Frame FSM: next state, phase/bit counters, shift register and data capture.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (com_rise_s) begin
          state_d   = ST_ALIGN;
          phase_d   = PH_HALF;
          bit_cnt_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (!com_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (phase_q == 8'd0) begin
          state_d = ST_SHIFT;
          phase_d = PH_FULL;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!com_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (phase_q == 8'd0) begin
          sr_d      = shift_word_s;
          bit_cnt_d = bit_cnt_q + 8'd1;
          phase_d   = PH_FULL;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef LINK_PARITY_EN
            state_d = ST_PARITY;
`else
            // Capture on the final shift so data and data_rdy appear together.
            state_d = ST_DONE;
            data_d  = shift_word_s;
            load_s  = 1'b1;
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
`ifdef LINK_PARITY_EN
      ST_PARITY: begin
        if (!com_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (phase_q == 8'd0) begin
          state_d = ST_DONE;
          if (parity_bad(sr_q, din_s)) begin
            err_d = 1'b1;
          end else begin
            data_d = sr_q;
            load_s = 1'b1;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
`endif
      ST_DONE: begin
        if (!com_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // data_rdy hold countdown, independent of the FSM state.
  always_comb begin
    if (load_s) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
    end else begin
      hold_d = 8'd0;
    end
    rdy_d = (hold_d != 8'd0);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      phase_q   <= 8'd0;
      bit_cnt_q <= 8'd0;
      sr_q      <= '0;
      data_q    <= '0;
      hold_q    <= 8'd0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      settle_q  <= 2'b00;
      low_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      hold_q    <= hold_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      settle_q  <= settle_d;
      low_q     <= low_d;
    end
  end

  assign data      = data_q;
  assign data_rdy  = rdy_q;
  assign frame_err = err_q;
  assign bit_cnt   = bit_cnt_q;

endmodule
